// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: shared constants and types for the DLFloat16 MAC datapath.
// DLFloat16 layout: [15] sign, [14:9] exponent (bias 31), [8:0] mantissa.
// 16'hFFFF is the combined NaN/Inf sentinel.
package dlfloat_pkg;

    localparam int unsigned     DLF_W    = 16;
    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam int unsigned     DLF_BIAS = 31;

    // Dot-product sequencer states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    function automatic logic dlf_is_nan(input logic [DLF_W-1:0] v);
        return v == DLF_NAN;
    endfunction

endpackage

// File: rtl/dlfloat_lat_timer.sv
// dlfloat_lat_timer: loadable down-counter used to pace MAC accumulator feedback.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load the counter with value (takes priority over counting)
//   value     - load value
//   expire    - high while the counter holds 1, i.e. the last counted cycle
module dlfloat_lat_timer #(
    parameter  int unsigned MAC_LAT = 3,
    localparam int unsigned CW      = $clog2(MAC_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == CW'(1));

endmodule

// File: rtl/dlfloat_dot_seq.sv
// dlfloat_dot_seq: dot-product sequencer in front of the accumulating DLFloat16 MAC.
// Accepts a job length, streams operand pairs over valid/ready, issues each pair
// to the MAC spaced by MAC_LAT+2 cycles, and returns mac_c as the result.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, cfg_len      - begin job of cfg_len pairs (sampled in IDLE only)
//   in_valid/in_ready   - operand pair handshake, in_a/in_b operands
//   mac_en, mac_clr     - one-cycle issue / accumulator-clear strobes
//   mac_a, mac_b        - registered operands to the MAC; mac_c accumulator in
//   res_valid/res_ready - result handshake, res_data final dot product
//   busy                - high in every state except IDLE
// Optional build macro DLF_NAN_FLUSH_EN: a sentinel operand sets a sticky flag,
// stops issuing, drains the remaining pairs and returns 16'hFFFF.
module dlfloat_dot_seq
    import dlfloat_pkg::*;
#(
    parameter int unsigned MAC_LAT = 3,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DLF_W-1:0] in_a,
    input  logic [DLF_W-1:0] in_b,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [DLF_W-1:0] mac_a,
    output logic [DLF_W-1:0] mac_b,
    input  logic [DLF_W-1:0] mac_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DLF_W-1:0] res_data,
    output logic             busy
);

    localparam int unsigned LAT_W = $clog2(MAC_LAT + 1);

    seq_state_t       state;
    logic [LEN_W-1:0] rem;
    logic             wait_done;
`ifdef DLF_NAN_FLUSH_EN
    logic             nan_flag;
`endif

    dlfloat_lat_timer #(
        .MAC_LAT (MAC_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_ISSUE),
        .value  (LAT_W'(MAC_LAT)),
        .expire (wait_done)
    );

    // Strobes and flags decode straight from the state register.
    assign in_ready  = (state == ST_LOAD);
    assign mac_en    = (state == ST_ISSUE);
    assign mac_clr   = (state == ST_CLEAR);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            res_data <= '0;
`ifdef DLF_NAN_FLUSH_EN
            nan_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem   <= cfg_len;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
`ifdef DLF_NAN_FLUSH_EN
                    nan_flag <= 1'b0;
`endif
                    if (rem == '0) begin
                        res_data <= DLF_ZERO;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (rem != '0) begin
                            rem <= rem - 1'b1;
                        end
`ifdef DLF_NAN_FLUSH_EN
                        // Once poisoned, every remaining pair is accepted and
                        // dropped back-to-back; the last one closes the job.
                        if (nan_flag || dlf_is_nan(in_a) || dlf_is_nan(in_b)) begin
                            nan_flag <= 1'b1;
                            if ((rem == LEN_W'(1)) || (rem == '0)) begin
                                res_data <= DLF_NAN;
                                state    <= ST_DONE;
                            end
                        end else begin
                            mac_a <= in_a;
                            mac_b <= in_b;
                            state <= ST_ISSUE;
                        end
`else
                        mac_a <= in_a;
                        mac_b <= in_b;
                        state <= ST_ISSUE;
`endif
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        if (rem != '0) begin
                            state <= ST_LOAD;
                        end else begin
                            res_data <= mac_c;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
